// File: rtl/noise_voice_sched_if.sv
// noise_voice_sched_if: voice request / LFSR control / noise word bundle for noise_voice_sched
interface noise_voice_sched_if #(parameter int NV = 8, IDW = 3, DSZ = 18);
  logic [NV-1:0]  req;
  logic           hold;
  logic           ovf_clr;
  logic [DSZ-1:0] lfsr_bits;
  logic           lfsr_step;
  logic           out_valid;
  logic [IDW-1:0] out_id;
  logic [DSZ-1:0] out_data;
  logic           busy;
  logic [NV-1:0]  ovf;
  modport master(output req, hold, ovf_clr, lfsr_bits,
                 input lfsr_step, out_valid, out_id, out_data, busy, ovf);
  modport slave(input req, hold, ovf_clr, lfsr_bits,
                output lfsr_step, out_valid, out_id, out_data, busy, ovf);
endinterface

// File: rtl/noise_voice_sched.sv
// noise_voice_sched: round-robin share of one LFSR noise source among NV voices
module noise_voice_sched #(
  parameter int NV    = 8,
  parameter int IDW   = 3,
  parameter int STEPS = 18,
  parameter int DSZ   = 18
) (
  input logic clk,
  input logic rst_n,
  noise_voice_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t         state;
  logic [4:0]     cnt;
  logic [IDW-1:0] ptr, id, pick, idx;
  logic [NV-1:0]  pend, clr;
  logic           found;
  // Search starts just past the last served voice, wrapping mod NV.
  always_comb begin
    pick = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 1; k <= NV; k++) begin
      idx = IDW'((int'(ptr) + k) % NV);
      if (!found && pend[idx]) begin
        pick = idx;
        found = 1'b1;
      end
    end
  end
  assign clr = (state == DONE) ? (NV'(1) << id) : '0;
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      ptr <= IDW'(NV - 1);
      id <= '0;
      pend <= '0;
      bus.ovf <= '0;
      bus.lfsr_step <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_id <= '0;
      bus.out_data <= '0;
    end else begin
      pend <= (pend & ~clr) | bus.req;
      bus.ovf <= (bus.ovf & ~{NV{bus.ovf_clr}}) | (bus.req & pend & ~clr);
      bus.out_valid <= 1'b0;
      case (state)
        IDLE: if (!bus.hold && found) begin
          id <= pick;
          cnt <= 5'(STEPS - 1);
          bus.lfsr_step <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: if (cnt == '0) begin
          bus.lfsr_step <= 1'b0;
          state <= DONE;
        end else cnt <= cnt - 5'd1;
        DONE: begin
          bus.out_data <= bus.lfsr_bits;
          bus.out_id <= id;
          bus.out_valid <= 1'b1;
          ptr <= id;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_noise_voice_sched.sv
// tb_noise_voice_sched: vector table, directed corner sequences and random traffic vs a timeline model
module tb_noise_voice_sched;
  localparam int NV = 8, IDW = 3, STEPS = 18, DSZ = 18;
  localparam logic [62:0] SEED = 63'h5A5A_1234_DEAD_BEEF;
  logic clk = 1'b0, rst_n = 1'b0, reseed = 1'b1;
  logic [62:0] sr;
  always #5 clk = ~clk;
  noise_voice_sched_if #(.NV(NV), .IDW(IDW), .DSZ(DSZ)) bus();
  noise_voice_sched #(.NV(NV), .IDW(IDW), .STEPS(STEPS), .DSZ(DSZ)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always @(posedge clk) sr <= reseed ? SEED : bus.lfsr_step ? {sr[61:0], sr[62] ^ sr[61]} : sr;
  assign bus.lfsr_bits = sr[DSZ-1:0];
  int n_pass = 0, n_chk = 0;
  logic [NV-1:0] m_pend, m_ovf;
  int m_ptr, m_t, m_t0, m_gid;
  bit m_g;
  logic m_step, m_valid, m_busy;
  logic [IDW-1:0] m_id;
  logic [DSZ-1:0] m_data;
  logic [62:0] m_sr;
  int first_step, first_valid, n_valid, n_step, last_t, spacing, prev_id, last_id;
  logic [IDW-1:0] first_id;
  logic [DSZ-1:0] first_data;
  function automatic logic [62:0] lfsr_adv(logic [62:0] s, int n);
    for (int i = 0; i < n; i++) s = {s[61:0], s[62] ^ s[61]};
    return s;
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, m_t);
  endtask
  // Grant timeline: chosen in IDLE cycle t0, steps t0+1..t0+STEPS, DONE at t0+STEPS+1.
  task automatic model_edge(input logic [NV-1:0] r, input logic h, input logic c);
    logic [NV-1:0] clr;
    int t;
    clr = '0;
    t = m_t;
    m_valid = 1'b0;
    if (m_g && t == m_t0 + STEPS + 1) begin
      m_valid = 1'b1;
      m_id = IDW'(m_gid);
      m_data = m_sr[DSZ-1:0];
      clr[m_gid] = 1'b1;
      m_ptr = m_gid;
      m_g = 0;
    end else if (!m_g && !h && m_pend != '0) begin
      for (int k = 1; k <= NV; k++)
        if (m_pend[(m_ptr + k) % NV]) begin
          m_gid = (m_ptr + k) % NV;
          break;
        end
      m_g = 1;
      m_t0 = t;
      m_sr = lfsr_adv(m_sr, STEPS);
    end
    m_ovf = (m_ovf & ~{NV{c}}) | (r & m_pend & ~clr);
    m_pend = (m_pend & ~clr) | r;
    m_t = t + 1;
    m_step = m_g && m_t <= m_t0 + STEPS;
    m_busy = m_g;
  endtask
  task automatic tick(input logic [NV-1:0] r, input logic h = 1'b0, input logic c = 1'b0);
    bus.req = r;
    bus.hold = h;
    bus.ovf_clr = c;
    @(posedge clk);
    model_edge(r, h, c);
    #1;
    check("cycle", {bus.lfsr_step, bus.out_valid, bus.busy, bus.ovf, bus.out_id, bus.out_data},
          {m_step, m_valid, m_busy, m_ovf, m_id, m_data});
    if (bus.lfsr_step) begin
      n_step++;
      if (first_step < 0) first_step = m_t;
    end
    if (bus.out_valid) begin
      n_valid++;
      if (first_valid < 0) begin
        first_valid = m_t;
        first_id = bus.out_id;
        first_data = bus.out_data;
      end
      spacing = last_t < 0 ? -1 : m_t - last_t;
      prev_id = last_id;
      last_t = m_t;
      last_id = int'(bus.out_id);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    reseed = 1'b1;
    bus.req = '0;
    bus.hold = 1'b0;
    bus.ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", {bus.lfsr_step, bus.out_valid, bus.busy, bus.ovf, bus.out_id, bus.out_data}, '0);
    rst_n = 1'b1;
    reseed = 1'b0;
    m_pend = '0; m_ovf = '0; m_ptr = NV - 1; m_t = 0; m_t0 = 0; m_gid = 0; m_g = 0;
    m_step = 0; m_valid = 0; m_busy = 0; m_id = '0; m_data = '0; m_sr = SEED;
    first_step = -1; first_valid = -1; n_valid = 0; n_step = 0;
    last_t = -1; spacing = -1; prev_id = 0; last_id = 0;
  endtask
  typedef struct { logic [NV-1:0] req; logic [IDW-1:0] id; int lat; } vec_t;
  vec_t tbl[6];
  logic [62:0] gold;
  initial begin
    tbl = '{'{8'h08, 3'd3, 21}, '{8'h81, 3'd0, 21}, '{8'h80, 3'd7, 21},
            '{8'h60, 3'd5, 21}, '{8'hF0, 3'd4, 21}, '{8'h06, 3'd1, 21}};
    gold = lfsr_adv(SEED, STEPS);
    foreach (tbl[i]) begin
      do_reset();
      tick(tbl[i].req);
      repeat (109) tick('0);
      check("first_lat", 64'(first_valid), 64'(tbl[i].lat));
      check("first_id", first_id, tbl[i].id);
      check("first_data", first_data, gold[DSZ-1:0]);
      check("n_valid", 64'(n_valid), 64'($countones(tbl[i].req)));
      check("ovf_none", bus.ovf, '0);
      if (i == 0) check("steps18", 64'(n_step), 64'(STEPS));
      if (i == 1) check("second_gap", 64'(spacing), 64'(STEPS + 2));
    end
    do_reset();
    repeat (400) begin
      tick(8'hFF);
      if (bus.out_valid && spacing > 0) begin
        check("rot_id", 64'(bus.out_id), 64'((prev_id + 1) % NV));
        check("rot_gap", 64'(spacing), 64'(STEPS + 2));
      end
    end
    check("ovf_all", bus.ovf, 8'hFF);
    tick(8'hFF, 1'b0, 1'b1);
    check("ovf_clr_vs_req", 64'(bus.ovf != '0), 64'd1);
    tick('0, 1'b0, 1'b1);
    check("ovf_clr", bus.ovf, '0);
    repeat (200) tick('0);
    do_reset();
    tick(8'h04);
    repeat (4) tick('0);
    tick(8'h04);
    repeat (40) tick('0);
    check("coalesce_n", 64'(n_valid), 64'd1);
    check("coalesce_ovf", 64'(bus.ovf[2]), 64'd1);
    do_reset();
    tick(8'h04);
    repeat (19) tick('0);
    check("done_cycle", {bus.busy, bus.lfsr_step}, 2'b10);
    tick(8'h04);
    repeat (40) tick('0);
    check("done_req_n", 64'(n_valid), 64'd2);
    do_reset();
    tick(8'h20, 1'b1);
    repeat (49) tick('0, 1'b1);
    check("hold_step", 64'(first_step), 64'hFFFF_FFFF_FFFF_FFFF);
    check("hold_busy", bus.busy, 1'b0);
    repeat (25) tick('0);
    check("hold_step_rise", 64'(first_step), 64'd51);
    check("hold_valid", 64'(first_valid), 64'd70);
    check("hold_id", first_id, 3'd5);
    do_reset();
    tick(8'h02);
    for (int i = 0; i < 30 && n_step < 9; i++) tick('0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", {bus.lfsr_step, bus.out_valid, bus.busy}, 3'b000);
    do_reset();
    tick(8'h40);
    repeat (30) tick('0);
    check("post_rst_id", first_id, 3'd6);
    check("post_rst_lat", 64'(first_valid), 64'd21);
    check("post_rst_steps", 64'(n_step), 64'(STEPS));
    check("post_rst_n", 64'(n_valid), 64'd1);
    do_reset();
    repeat (1500) begin
      logic [NV-1:0] r;
      r = '0;
      for (int b = 0; b < NV; b++) r[b] = ($urandom_range(0, 15) == 0);
      tick(r, $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
